// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state/owner encoding for the FIFO write arbiter
package fifo_arb_pkg;

  // State value doubles as the o_Owner code seen by the parent.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester round-robin burst arbiter feeding one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_A_Req,
  input  logic [WIDTH-1:0] i_A_Data,
  output logic             o_A_Ack,
  input  logic             i_B_Req,
  input  logic [WIDTH-1:0] i_B_Data,
  output logic             o_B_Ack,
  input  logic             i_Full,
  output logic             o_Wr_DV,
  output logic [WIDTH-1:0] o_Wr_Data,
  output logic [1:0]       o_Owner
);

  localparam int CW = $clog2(BURST + 1);

  arb_state_t     state, state_nxt;
  logic           last_b, last_b_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           accept;
  logic           burst_done;
  logic           own_req;
  logic           other_req;
  logic [WIDTH-1:0] acc_data;

  assign o_Owner = state;

  always_comb begin
    o_A_Ack    = i_Rst_L && (state == OWN_A) && i_A_Req && !i_Full;
    o_B_Ack    = i_Rst_L && (state == OWN_B) && i_B_Req && !i_Full;
    accept     = o_A_Ack || o_B_Ack;
    acc_data   = o_B_Ack ? i_B_Data : i_A_Data;
    own_req    = (state == OWN_B) ? i_B_Req : i_A_Req;
    other_req  = (state == OWN_B) ? i_A_Req : i_B_Req;
    // Burst end only counts on a real accept, so a full FIFO never ends a grant.
    burst_done = accept && (cnt == CW'(BURST - 1));

    state_nxt  = state;
    last_b_nxt = last_b;
    cnt_nxt    = accept ? cnt + 1'b1 : cnt;

    case (state)
      IDLE: begin
        if (i_A_Req && i_B_Req) state_nxt = last_b ? OWN_A : OWN_B;
        else if (i_A_Req)       state_nxt = OWN_A;
        else if (i_B_Req)       state_nxt = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (burst_done || !own_req) begin
          last_b_nxt = (state == OWN_B);
          cnt_nxt    = '0;
          if (other_req)    state_nxt = (state == OWN_A) ? OWN_B : OWN_A;
          else if (own_req) state_nxt = state;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      cnt       <= '0;
      o_Wr_DV   <= 1'b0;
      o_Wr_Data <= '0;
    end else begin
      state   <= state_nxt;
      last_b  <= last_b_nxt;
      cnt     <= cnt_nxt;
      o_Wr_DV <= accept;
      if (accept) o_Wr_Data <= acc_data;
    end
  end

endmodule
